// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - bundle of fetch, load/store and memory-macro signals for the arbiter
//
// Purpose: groups every non-clock/reset signal of unified_mem_arbiter.
//   slave  : arbiter view (requests and mem_rdata_i in; results, stalls and memory strobes out)
//   master : core/memory view (the opposite directions)
// Signals:
//   inst_ce_i, inst_addr_i                  fetch request and address
//   inst_o, inst_stall_o                    fetched word and fetch stall
//   dmem_re_i, dmem_we_i, dmem_addr_i,
//   dmem_wdata_i, dmem_wmask_i              load/store request
//   dmem_rdata_o, dmem_stall_o              load data and data stall
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i                single-port memory macro port
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              inst_ce_i;
   logic [ADDR_W-1:0] inst_addr_i;
   logic [31:0]       inst_o;
   logic              inst_stall_o;
   logic              dmem_re_i;
   logic              dmem_we_i;
   logic [ADDR_W-1:0] dmem_addr_i;
   logic [31:0]       dmem_wdata_i;
   logic [3:0]        dmem_wmask_i;
   logic [31:0]       dmem_rdata_o;
   logic              dmem_stall_o;
   logic              mem_en_o;
   logic [3:0]        mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [31:0]       mem_rdata_i;

   modport slave (
      input  inst_ce_i, inst_addr_i,
      input  dmem_re_i, dmem_we_i, dmem_addr_i, dmem_wdata_i, dmem_wmask_i,
      input  mem_rdata_i,
      output inst_o, inst_stall_o,
      output dmem_rdata_o, dmem_stall_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output inst_ce_i, inst_addr_i,
      output dmem_re_i, dmem_we_i, dmem_addr_i, dmem_wdata_i, dmem_wmask_i,
      output mem_rdata_i,
      input  inst_o, inst_stall_o,
      input  dmem_rdata_o, dmem_stall_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port synchronous memory between fetch and load/store
//
// Purpose: arbitrates instruction fetch and MEM-stage load/store onto one memory macro.
//   Reads occupy LAT+1 cycles (issue, LAT-1 waits, completion); stores finish in their issue cycle.
//   Stalls go back to each requester until its access completes.
// Parameters: LAT (read latency in edges, 1..4), ADDR_W (address width).
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  unified_mem_arbiter_if.slave (fetch port, load/store port, memory port)
// Optional feature: define ARB_FAIRNESS_EN for alternating priority under contention;
//   otherwise data requests always win over fetch.
module unified_mem_arbiter #(
   parameter int LAT    = 1,
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   unified_mem_arbiter_if.slave    bus
);
   localparam int CW = $clog2(LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(LAT);

   typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [31:0]       ihold_q, ihold_d;
   logic [31:0]       dhold_q, dhold_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              last_data_q, last_data_d;   // 1: data port got the last grant

   logic data_req, can_issue, pick_data, pick_fetch;
   logic read_done, fetch_done, load_done, store_done;

   always_comb begin
      data_req  = bus.dmem_re_i | bus.dmem_we_i;
      // Nothing issues while reset is held, so the memory strobes stay quiet.
      can_issue = (state_q == IDLE) & ~rst;
`ifdef ARB_FAIRNESS_EN
      pick_data = can_issue & data_req & (~bus.inst_ce_i | ~last_data_q);
`else
      pick_data = can_issue & data_req;
`endif
      pick_fetch = can_issue & bus.inst_ce_i & ~pick_data;

      read_done  = (state_q != IDLE) && (cnt_q == LAT_C);
      // A requester that dropped its request mid-read does not take the result.
      fetch_done = read_done && (state_q == RD_I) && bus.inst_ce_i;
      load_done  = read_done && (state_q == RD_D) && bus.dmem_re_i;
      store_done = pick_data & bus.dmem_we_i;

      state_d     = state_q;
      cnt_d       = cnt_q;
      ihold_d     = ihold_q;
      dhold_d     = dhold_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      last_data_d = last_data_q;

      if (pick_data) begin
         addr_d      = bus.dmem_addr_i;
         wdata_d     = bus.dmem_wdata_i;
         last_data_d = 1'b1;
         if (bus.dmem_re_i) begin
            state_d = RD_D;
            cnt_d   = CW'(1);
         end
      end else if (pick_fetch) begin
         addr_d      = bus.inst_addr_i;
         wdata_d     = 32'h0;
         last_data_d = 1'b0;
         state_d     = RD_I;
         cnt_d       = CW'(1);
      end else if (state_q != IDLE) begin
         if (read_done) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (fetch_done) ihold_d = bus.mem_rdata_i;
      if (load_done)  dhold_d = bus.mem_rdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ihold_q     <= 32'h0;
         dhold_q     <= 32'h0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         last_data_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ihold_q     <= ihold_d;
         dhold_q     <= dhold_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         last_data_q <= last_data_d;
      end
   end

   // addr_d/wdata_d equal the held values outside an issue cycle.
   assign bus.mem_en_o     = pick_data | pick_fetch;
   assign bus.mem_we_o     = store_done ? bus.dmem_wmask_i : 4'b0000;
   assign bus.mem_addr_o   = addr_d;
   assign bus.mem_wdata_o  = wdata_d;
   assign bus.inst_o       = fetch_done ? bus.mem_rdata_i : ihold_q;
   assign bus.dmem_rdata_o = load_done ? bus.mem_rdata_i : dhold_q;
   assign bus.inst_stall_o = bus.inst_ce_i & ~fetch_done;
   assign bus.dmem_stall_o = data_req & ~(load_done | store_done);
endmodule
